pulse_meter: RTL and testbench

- Inverse of the fixed-delay timer: measures the high-time of an external pulse in whole microseconds and returns it to a controller.
- A free-running microsecond prescaler drives a saturating width counter.
- Results are handed out over a valid/ready handshake.
- Sits beside the fixed-delay timers in the sensor/interface timing path; for example, it measures echo or response pulses that the delay blocks trigger.

---
 rtl/pulse_meter_pkg.sv | 17 +
 rtl/us_tick_gen.sv | 31 +++
 rtl/pulse_meter.sv | 155 +++++++++++++++
 tb/tb_pulse_meter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse width meter: FSM state encodings and prescaler sizing.
package pulse_meter_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle     = 3'd0;
    localparam state_t StWaitLow  = 3'd1;
    localparam state_t StWaitHigh = 3'd2;
    localparam state_t StMeasure  = 3'd3;
    localparam state_t StHold     = 3'd4;

    // Prescaler counter width; never narrower than one bit.
    function automatic int unsigned presc_width(input int unsigned freq_mhz);
        return (freq_mhz > 1) ? $clog2(freq_mhz) : 1;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick generator: one-cycle tick every FREQ_MHZ clocks while run is high.
module us_tick_gen
    import pulse_meter_pkg::*;
#(
    parameter int unsigned FREQ_MHZ = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned CntW = presc_width(FREQ_MHZ);
    localparam logic [CntW-1:0] CntMax = CntW'(FREQ_MHZ - 1);

    logic [CntW-1:0] r_cnt;

    assign tick = run && (r_cnt == CntMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= tick ? '0 : r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/pulse_meter.sv
// Measures pulse high-time in whole microseconds, handed out over valid/ready.
// Optional macro PULSE_METER_GLITCH_FILTER_EN adds a 4-cycle stability filter on the input.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned FREQ_MHZ   = 50,
    parameter int unsigned WIDTH_BITS = 16,
    parameter int unsigned TIMEOUT_US = 30000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  pulse_in,
    output logic [WIDTH_BITS-1:0] width_us,
    output logic                  timeout,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy
);

    localparam logic [WIDTH_BITS-1:0] TimeoutVal = WIDTH_BITS'(TIMEOUT_US);

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_p_s;
    logic                  r_p_s_d;
    state_t                r_state;
    logic [WIDTH_BITS-1:0] r_count;
    logic [WIDTH_BITS-1:0] r_width;
    logic                  r_timeout;
    logic                  r_valid;

    logic w_rise;
    logic w_fall;
    logic w_run;
    logic w_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_p_s_d <= 1'b0;
        end else begin
            r_sync1 <= pulse_in;
            r_sync2 <= r_sync1;
            r_p_s_d <= r_p_s;
        end
    end

`ifdef PULSE_METER_GLITCH_FILTER_EN
    logic [3:0] r_hist;

    // p_s only follows a level seen on the synced input for four consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 4'b0000;
            r_p_s  <= 1'b0;
        end else begin
            r_hist <= {r_hist[2:0], r_sync2};
            if (r_hist == 4'b1111) begin
                r_p_s <= 1'b1;
            end else if (r_hist == 4'b0000) begin
                r_p_s <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_s <= 1'b0;
        end else begin
            r_p_s <= r_sync2;
        end
    end
`endif

    assign w_rise = r_p_s & ~r_p_s_d;
    assign w_fall = ~r_p_s & r_p_s_d;
    assign w_run  = (r_state == StMeasure);

    // Held clear outside MEASURE, so the first MEASURE cycle starts from zero.
    us_tick_gen #(
        .FREQ_MHZ(FREQ_MHZ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(~w_run),
        .run  (w_run),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!w_run) begin
            r_count <= '0;
        end else if (w_tick && (r_count != TimeoutVal)) begin
            r_count <= r_count + WIDTH_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_width   <= '0;
            r_timeout <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (enable) r_state <= StWaitLow;
                end
                StWaitLow: begin
                    if (!enable) r_state <= StIdle;
                    else if (!r_p_s) r_state <= StWaitHigh;
                end
                StWaitHigh: begin
                    if (!enable) r_state <= StIdle;
                    else if (w_rise) r_state <= StMeasure;
                end
                StMeasure: begin
                    // Abort beats timeout, and timeout beats a coincident fall.
                    if (!enable) begin
                        r_state <= StIdle;
                    end else if (r_count == TimeoutVal) begin
                        r_width   <= TimeoutVal;
                        r_timeout <= 1'b1;
                        r_valid   <= 1'b1;
                        r_state   <= StHold;
                    end else if (w_fall) begin
                        r_width   <= r_count + {{(WIDTH_BITS-1){1'b0}}, w_tick};
                        r_timeout <= 1'b0;
                        r_valid   <= 1'b1;
                        r_state   <= StHold;
                    end
                end
                StHold: begin
                    if (result_ready) begin
                        r_valid   <= 1'b0;
                        r_width   <= '0;
                        r_timeout <= 1'b0;
                        r_state   <= enable ? StWaitLow : StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign width_us     = r_width;
    assign timeout      = r_timeout;
    assign result_valid = r_valid;
    assign busy         = w_run;

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter (FREQ_MHZ=50, TIMEOUT_US=10); results checked on acceptance.
module tb_pulse_meter;

    localparam int unsigned FreqMhz   = 50;
    localparam int unsigned WidthBits = 16;
    localparam int unsigned TimeoutUs = 10;

    logic                 clk;
    logic                 rst;
    logic                 enable;
    logic                 pulse_in;
    logic [WidthBits-1:0] width_us;
    logic                 timeout;
    logic                 result_valid;
    logic                 result_ready;
    logic                 busy;

    int errors = 0;
    int checks = 0;

    // Expected results as {timeout, width_us}.
    logic [WidthBits:0] exp_q[$];

    pulse_meter #(
        .FREQ_MHZ  (FreqMhz),
        .WIDTH_BITS(WidthBits),
        .TIMEOUT_US(TimeoutUs)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pulse_in    (pulse_in),
        .width_us    (width_us),
        .timeout     (timeout),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got width=%0d timeout=%0b, required no result",
                         width_us, timeout);
            end else begin
                logic [WidthBits:0] exp_v;
                exp_v = exp_q.pop_front();
                if ({timeout, width_us} !== exp_v) begin
                    errors++;
                    $display("FAIL result: got width=%0d timeout=%0b, required width=%0d timeout=%0b",
                             width_us, timeout, exp_v[WidthBits-1:0], exp_v[WidthBits]);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        @(posedge clk);
        #1 pulse_in = 1'b1;
        repeat (n) @(posedge clk);
        #1 pulse_in = 1'b0;
    endtask

    task automatic expect_result(input int w, input bit t);
        exp_q.push_back({t, WidthBits'(w)});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_quiet(input string name);
        @(negedge clk);
        checks++;
        if ({result_valid, busy, timeout, width_us} !== '0) begin
            errors++;
            $display("FAIL %s: got valid=%0b busy=%0b timeout=%0b width=%0d, required all 0",
                     name, result_valid, busy, timeout, width_us);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        pulse_in = 1'b0;
        result_ready = 1'b1;
        cycles(3);
        check_quiet("reset_outputs");
        #1 rst = 1'b0;
        cycles(2);
        check_quiet("post_reset_idle");
    endtask

    task automatic test_basic();
        int vcnt;
        enable = 1'b1;
        cycles(10);
        expect_result(5, 1'b0);
        @(posedge clk);
        #1 pulse_in = 1'b1;
        cycles(100);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_during_pulse: got %0b, required 1", busy);
        end
        @(posedge clk);
        repeat (149) @(posedge clk);
        #1 pulse_in = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (result_valid) vcnt++;
        end
        checks++;
        if (vcnt != 1) begin
            errors++;
            $display("FAIL valid_one_cycle: got %0d valid cycles, required 1", vcnt);
        end
        drain("basic");
    endtask

    task automatic test_rounding();
        int widths[3] = '{249, 50, 49};
        int exps[3]   = '{4, 1, 0};
        for (int i = 0; i < 3; i++) begin
            expect_result(exps[i], 1'b0);
            pulse(widths[i]);
            cycles(20);
        end
        drain("rounding");
    endtask

    task automatic test_timeout();
        int n;
        expect_result(TimeoutUs, 1'b1);
        @(posedge clk);
        #1 pulse_in = 1'b1;
        n = 0;
        while (!result_valid && n < 800) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!result_valid || n < 495 || n > 515) begin
            errors++;
            $display("FAIL timeout_latency: got valid=%0b after %0d cycles, required 495..515",
                     result_valid, n);
        end
        cycles(2000 - n);
        pulse_in = 1'b0;
        drain("timeout");
        cycles(20);
        expect_result(2, 1'b0);
        pulse(100);
        cycles(20);
        drain("after_timeout");
    endtask

    task automatic test_prearmed();
        enable = 1'b0;
        cycles(3);
        pulse_in = 1'b1;
        cycles(5);
        enable = 1'b1;
        cycles(100);
        pulse_in = 1'b0;
        cycles(20);
        expect_result(3, 1'b0);
        pulse(150);
        cycles(30);
        drain("prearmed");
    endtask

    task automatic test_back_to_back();
        int n;
        result_ready = 1'b0;
        expect_result(2, 1'b0);
        pulse(100);
        n = 0;
        while (!result_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 2) pulse_in = 1'b1;
            if (i == 12) pulse_in = 1'b0;
            @(negedge clk);
            checks++;
            if (result_valid !== 1'b1 || width_us !== WidthBits'(2) || timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got valid=%0b width=%0d timeout=%0b, required 1/2/0",
                         i, result_valid, width_us, timeout);
            end
            @(posedge clk);
            #1;
        end
        result_ready = 1'b1;
        cycles(5);
        drain("hold_accept");
        expect_result(2, 1'b0);
        pulse(100);
        cycles(20);
        drain("after_hold");
    endtask

    task automatic test_abort();
        @(posedge clk);
        #1 pulse_in = 1'b1;
        cycles(120);
        enable = 1'b0;
        cycles(3);
        check_quiet("enable_abort");
        cycles(30);
        pulse_in = 1'b0;
        cycles(20);
        check_quiet("enable_abort_after_fall");
        enable = 1'b1;
        cycles(10);
        pulse_in = 1'b1;
        cycles(100);
        rst = 1'b1;
        cycles(2);
        check_quiet("reset_mid_measure");
        pulse_in = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(20);
        check_quiet("after_reset_release");
        expect_result(1, 1'b0);
        pulse(60);
        cycles(20);
        drain("after_abort");
    endtask

    task automatic test_glitch();
`ifndef PULSE_METER_GLITCH_FILTER_EN
        expect_result(0, 1'b0);
`endif
        pulse(2);
        cycles(30);
        drain("glitch");
        check_quiet("glitch_quiet");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_timeout();
        test_prearmed();
        test_back_to_back();
        test_abort();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
